pc_sequencer: RTL and testbench

Multicycle fetch/execute controller for the program counter. It sequences the enable-only PC counter. For each instruction it requests a fetch from instruction memory, waits for the memory handshake, and holds the execute phase for a fixed number of cycles. It then pulses `pc_enable` so the counter advances by one. It stops when the last program address has executed, and flags an error if instruction memory stalls too long.

---
 rtl/pc_sequencer_pkg.sv | 20 ++
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_sequencer_step_timer.sv | 35 +++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter fetch/execute sequencer.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  localparam int unsigned DEF_EXEC_CYCLES = 3;
  localparam int unsigned DEF_TIMEOUT     = 15;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory handshake and PC-counter hookup for pc_sequencer.
interface pc_sequencer_if #(
  parameter int unsigned NBITS = 8
);
  logic             imem_req;
  logic             imem_ready;
  logic             ir_load;
  logic             pc_enable;
  logic [NBITS-1:0] pc;

  modport master (
    output imem_req,
    output ir_load,
    output pc_enable,
    input  imem_ready,
    input  pc
  );

  modport slave (
    input  imem_req,
    input  ir_load,
    input  pc_enable,
    output imem_ready,
    output pc
  );
endinterface

// File: rtl/pc_sequencer_step_timer.sv
// Saturating up-counter with clear, increment and terminal-count flag.
module step_timer #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_o = (count_q == LAST);

  // Clear wins over increment; holding at LAST keeps the count from wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && !tc_o)
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute controller that steps an enable-only PC counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned NBITS       = 8,
  parameter int unsigned EXEC_CYCLES = DEF_EXEC_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] last_addr,
  output logic             busy,
  output logic             done,
  output logic             error,
  pc_sequencer_if.master   bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned EXEC_W = cnt_width(EXEC_CYCLES);

  state_e state_q, state_d;

  logic wait_clr, wait_inc, wait_tc;
  logic exec_clr, exec_inc, exec_tc;

  step_timer #(
    .WIDTH(WAIT_W),
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .reset(reset),
    .clr_i(wait_clr),
    .inc_i(wait_inc),
    .tc_o (wait_tc)
  );

  step_timer #(
    .WIDTH(EXEC_W),
    .LIMIT(EXEC_CYCLES)
  ) u_exec_timer (
    .clk  (clk),
    .reset(reset),
    .clr_i(exec_clr),
    .inc_i(exec_inc),
    .tc_o (exec_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Ready on the last allowed wait cycle still reaches EXEC ahead of the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH: begin
        if (bus.imem_ready)
          state_d = EXEC;
        else if (wait_tc)
          state_d = ERROR;
      end
      EXEC: begin
        if (exec_tc)
          state_d = (bus.pc == last_addr) ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      ERROR:   if (start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Both timers sit at zero outside their own state and clear on the way out.
  always_comb begin
    wait_inc = (state_q == FETCH) && !bus.imem_ready;
    wait_clr = (state_q != FETCH) || (state_d != FETCH);
    exec_inc = (state_q == EXEC);
    exec_clr = (state_q != EXEC) || (state_d != EXEC);
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.ir_load   = 1'b0;
    bus.pc_enable = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (state_q)
      FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_load  = bus.imem_ready;
        busy         = 1'b1;
      end
      EXEC: begin
        bus.pc_enable = exec_tc;
        busy          = 1'b1;
      end
      DONE:    done  = 1'b1;
      ERROR:   error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer driving a behavioural enable-only PC counter.
module tb_pc_sequencer;

  localparam int unsigned NBITS       = 8;
  localparam int unsigned EXEC_CYCLES = 3;
  localparam int unsigned TIMEOUT     = 4;
  localparam int unsigned MAXC        = 256;

  localparam int REQ = 6'b100000;
  localparam int IRL = 6'b010000;
  localparam int PCE = 6'b001000;
  localparam int BSY = 6'b000100;
  localparam int DON = 6'b000010;
  localparam int ERR = 6'b000001;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NBITS-1:0] last_addr;
  logic             busy, done, error;

  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;
  logic [NBITS-1:0] model_pc;

  pc_sequencer_if #(.NBITS(NBITS)) bus_if ();

  pc_sequencer #(
    .NBITS      (NBITS),
    .EXEC_CYCLES(EXEC_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .last_addr(last_addr),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  // PC counter sharing the sequencer reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bus_if.pc <= '0;
    else if (bus_if.pc_enable)
      bus_if.pc <= bus_if.pc + 1'b1;
  end

  typedef struct {
    int unsigned n_instr;
    int unsigned wait0;
    bit          noise;
    int          exp_irl;
    int          exp_pce;
    int          exp_npce;
    int          exp_done;
    int          exp_err;
    int          exp_boff;
    int          exp_dpc;
  } vec_t;

  vec_t vecs[5];

  function automatic int outs();
    return int'({bus_if.imem_req, bus_if.ir_load, bus_if.pc_enable, busy, done, error});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    bus_if.imem_ready = 1'b0;
    last_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 0);
    check("reset_pc", int'(bus_if.pc), 0);
    reset = 1'b1;
    model_pc = '0;
    next_cycle();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int first_irl = -1, first_pce = -1, first_done = -1, first_err = -1, boff = -1;
    int npce = 0;
    bit seen_busy = 0;
    last_addr = model_pc + NBITS'(v.n_instr - 1);
    for (int k = 0; k < 24; k++) begin
      start = (k == 0) || (v.noise && k == 3);
      bus_if.imem_ready = (k > int'(v.wait0));
      @(negedge clk);
      if (bus_if.ir_load && first_irl < 0) first_irl = k;
      if (bus_if.pc_enable) begin
        npce++;
        if (first_pce < 0) first_pce = k;
      end
      if (done && first_done < 0) first_done = k;
      if (error && first_err < 0) first_err = k;
      if (seen_busy && !busy && boff < 0) boff = k;
      seen_busy = seen_busy | busy;
      next_cycle();
    end
    start = 1'b0;
    check($sformatf("vec%0d_irl_cycle", idx), first_irl, v.exp_irl);
    check($sformatf("vec%0d_pce_cycle", idx), first_pce, v.exp_pce);
    check($sformatf("vec%0d_pce_count", idx), npce, v.exp_npce);
    check($sformatf("vec%0d_done_cycle", idx), first_done, v.exp_done);
    check($sformatf("vec%0d_err_cycle", idx), first_err, v.exp_err);
    check($sformatf("vec%0d_busy_off", idx), boff, v.exp_boff);
    model_pc = model_pc + NBITS'(v.exp_dpc);
    check($sformatf("vec%0d_pc_end", idx), int'(bus_if.pc), int'(model_pc));
  endtask

  // Expected trace built per instruction from its wait count and fixed execute length.
  task automatic run_random(input int run, input int unsigned n, input bit timeout_last);
    int               exp_o [MAXC];
    logic [NBITS-1:0] exp_pc [MAXC];
    bit               rdy [MAXC];
    bit               noise_ok [MAXC];
    int unsigned      t = 1;
    int unsigned      len;
    int unsigned      w;
    int unsigned      cnt = 0;
    bit               timed_out = 0;
    logic [NBITS-1:0] p0 = model_pc;

    for (int k = 0; k < int'(MAXC); k++) begin
      exp_o[k] = 0;
      rdy[k] = 1'($urandom_range(0, 1));
      noise_ok[k] = 0;
    end
    for (int unsigned i = 0; i < n; i++) begin
      w = (timeout_last && i == n - 1) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
      if (w >= TIMEOUT) begin
        for (int unsigned j = 0; j < TIMEOUT; j++) begin
          exp_o[t+j] = REQ | BSY;
          rdy[t+j] = 0;
          noise_ok[t+j] = 1;
        end
        t += TIMEOUT;
        for (int unsigned j = 0; j < 4; j++) exp_o[t+j] = ERR;
        timed_out = 1;
      end else begin
        for (int unsigned j = 0; j < w; j++) begin
          exp_o[t+j] = REQ | BSY;
          rdy[t+j] = 0;
          noise_ok[t+j] = 1;
        end
        exp_o[t+w] = REQ | IRL | BSY;
        rdy[t+w] = 1;
        noise_ok[t+w] = 1;
        for (int unsigned j = 1; j <= EXEC_CYCLES; j++) begin
          exp_o[t+w+j] = BSY;
          noise_ok[t+w+j] = 1;
        end
        exp_o[t+w+EXEC_CYCLES] |= PCE;
        t += w + EXEC_CYCLES + 1;
      end
    end
    if (timed_out) begin
      len = t + 4;
    end else begin
      exp_o[t] = DON;
      noise_ok[t] = 1;
      len = t + 3;
    end
    for (int k = 0; k < int'(MAXC); k++) begin
      exp_pc[k] = p0 + NBITS'(cnt);
      if ((exp_o[k] & PCE) != 0) cnt++;
    end

    last_addr = p0 + NBITS'(n - 1);
    for (int k = 0; k < int'(len); k++) begin
      start = (k == 0) || (noise_ok[k] && $urandom_range(0, 3) == 0);
      bus_if.imem_ready = rdy[k];
      @(negedge clk);
      check($sformatf("rnd%0d_c%0d_outs", run, k), outs(), exp_o[k]);
      check($sformatf("rnd%0d_c%0d_pc", run, k), int'(bus_if.pc), int'(exp_pc[k]));
      next_cycle();
    end
    start = 1'b0;
    if (timed_out)
      do_reset();
    else
      model_pc = p0 + NBITS'(n);
  endtask

  initial begin
    int got_done;

    vecs[0] = '{3, 0, 0,  1,  4, 3, 13, -1, 13, 3};
    vecs[1] = '{2, 0, 1,  1,  4, 2,  9, -1,  9, 2};
    vecs[2] = '{1, 2, 0,  3,  6, 1,  7, -1,  7, 1};
    vecs[3] = '{1, 3, 0,  4,  7, 1,  8, -1,  8, 1};
    vecs[4] = '{1, 4, 0, -1, -1, 0, -1,  5,  5, 0};

    do_reset();
    @(negedge clk);
    check("idle_after_reset_outs", outs(), 0);
    next_cycle();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Leaving ERROR: error holds until FETCH is entered, then a normal instruction runs.
    last_addr = model_pc;
    start = 1'b1;
    bus_if.imem_ready = 1'b1;
    @(negedge clk);
    check("err_hold_outs", outs(), ERR);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("err_recover_outs", outs(), REQ | IRL | BSY);
    got_done = -1;
    for (int k = 2; k < 20; k++) begin
      next_cycle();
      @(negedge clk);
      if (done && got_done < 0) got_done = k;
    end
    next_cycle();
    check("err_recover_done_cycle", got_done, 5);
    model_pc = model_pc + 1'b1;
    check("err_recover_pc", int'(bus_if.pc), int'(model_pc));

    // Reset landing in the second EXEC cycle must swallow the pending pc_enable.
    last_addr = model_pc + 8'd5;
    start = 1'b1;
    bus_if.imem_ready = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("midrst_pre_outs", outs(), BSY);
    reset = 1'b0;
    #1;
    check("midrst_outs", outs(), 0);
    check("midrst_pc", int'(bus_if.pc), 0);
    next_cycle();
    @(negedge clk);
    check("midrst_hold_outs", outs(), 0);
    reset = 1'b1;
    model_pc = '0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("midrst_after%0d_outs", k), outs(), 0);
      check($sformatf("midrst_after%0d_pc", k), int'(bus_if.pc), 0);
    end
    next_cycle();

    for (int r = 0; r < 14; r++)
      run_random(r, $urandom_range(1, 6), ($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
